// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with a 2-entry output buffer
// Decodes the format and immediate on push; the consumer sees the head entry straight from storage.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [31:0]     w_raw;
  logic [31:0]     w_shamt;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic [2:0]      w_funct3;
  logic            w_push;
  logic            w_pop;

  logic [XLEN-1:0] r_imm     [2];
  logic [4:0]      r_rd      [2];
  logic [4:0]      r_rs1     [2];
  logic [4:0]      r_rs2     [2];
  logic [2:0]      r_fmt     [2];
  logic            r_illegal [2];
  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;

  assign w_funct3 = instr_word[14:12];
  assign w_shamt  = (XLEN == 64) ? {26'd0, instr_word[25:20]} : {27'd0, instr_word[24:20]};

  // w_raw holds the immediate already sign-extended to 32 bits; the cast widens it to XLEN.
  always_comb begin
    w_raw     = 32'd0;
    w_fmt     = 3'd7;
    w_illegal = 1'b0;
    case (instr_word[6:0])
      7'b0110111, 7'b0010111: begin
        w_fmt = 3'd4;
        w_raw = {instr_word[31:12], 12'd0};
      end
      7'b1101111: begin
        w_fmt = 3'd5;
        w_raw = {{11{instr_word[31]}}, instr_word[31], instr_word[19:12],
                 instr_word[20], instr_word[30:21], 1'b0};
      end
      7'b0010011: begin
        w_fmt = 3'd1;
        if (SHAMT_ZEXT && (w_funct3 == 3'b001 || w_funct3 == 3'b101))
          w_raw = w_shamt;
        else
          w_raw = {{20{instr_word[31]}}, instr_word[31:20]};
      end
      7'b1100111, 7'b0000011, 7'b1110011: begin
        w_fmt = 3'd1;
        w_raw = {{20{instr_word[31]}}, instr_word[31:20]};
      end
      7'b0100011: begin
        w_fmt = 3'd2;
        w_raw = {{20{instr_word[31]}}, instr_word[31:25], instr_word[11:7]};
      end
      7'b1100011: begin
        w_fmt = 3'd3;
        w_raw = {{19{instr_word[31]}}, instr_word[31], instr_word[7],
                 instr_word[30:25], instr_word[11:8], 1'b0};
      end
      7'b0110011: begin
        w_fmt = 3'd0;
      end
      default: begin
        w_fmt     = 3'd7;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm = XLEN'($signed(w_raw));

  assign in_ready  = (r_count != 2'd2) && !rst;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_imm[i]     <= '0;
        r_rd[i]      <= 5'd0;
        r_rs1[i]     <= 5'd0;
        r_rs2[i]     <= 5'd0;
        r_fmt[i]     <= 3'd0;
        r_illegal[i] <= 1'b0;
      end
    end else if (flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_imm[r_wr_ptr]     <= w_imm;
        r_rd[r_wr_ptr]      <= instr_word[11:7];
        r_rs1[r_wr_ptr]     <= instr_word[19:15];
        r_rs2[r_wr_ptr]     <= instr_word[24:20];
        r_fmt[r_wr_ptr]     <= w_fmt;
        r_illegal[r_wr_ptr] <= w_illegal;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)
        r_count <= r_count + 2'd1;
      else if (w_pop && !w_push)
        r_count <= r_count - 2'd1;
    end
  end

  assign imm     = r_imm[r_rd_ptr];
  assign rd      = r_rd[r_rd_ptr];
  assign rs1     = r_rs1[r_rd_ptr];
  assign rs2     = r_rs2[r_rd_ptr];
  assign fmt     = r_fmt[r_rd_ptr];
  assign illegal = r_illegal[r_rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench for imm_gen_pipe (XLEN=32 shamt zero-extend, XLEN=64 plain I-imm)
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr_word = 32'd0;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] imm_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  fmt_a;
  logic        in_ready_b, out_valid_b, illegal_b;
  logic [63:0] imm_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  fmt_b;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr_word(instr_word), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm(imm_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .fmt(fmt_a), .illegal(illegal_a)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr_word(instr_word), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm(imm_b), .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b), .fmt(fmt_b), .illegal(illegal_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: immediates built as signed integers from the field values.
  function automatic void ref_dec(input logic [31:0] w, input int xlen, input bit sz,
                                  output logic [63:0] o_imm, output logic [2:0] o_fmt,
                                  output logic o_ill);
    longint v;
    v = 0;
    o_ill = 1'b0;
    case (w[6:0])
      7'h37, 7'h17: begin
        o_fmt = 3'd4;
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v = v - (longint'(1) << 32);
      end
      7'h6F: begin
        o_fmt = 3'd5;
        v = longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * (1 << 12)
          + longint'(w[20]) * (1 << 11) + longint'(w[30:21]) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      7'h67, 7'h03, 7'h13, 7'h73: begin
        o_fmt = 3'd1;
        if (w[6:0] == 7'h13 && sz && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
          v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
        else begin
          v = longint'(w[31:20]);
          if (v >= 2048) v = v - 4096;
        end
      end
      7'h23: begin
        o_fmt = 3'd2;
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        o_fmt = 3'd3;
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h33: o_fmt = 3'd0;
      default: begin
        o_fmt = 3'd7;
        o_ill = 1'b1;
      end
    endcase
    o_imm = 64'(v);
    if (xlen == 32) o_imm = o_imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  task automatic check_state();
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
    chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
    chk("out_valid_a", 64'(out_valid_a), 64'(q.size() > 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_dec(q[0], 32, 1'b1, ei, ef, el);
      chk("imm_a", 64'(imm_a), ei);
      chk("fmt_a", 64'(fmt_a), 64'(ef));
      chk("illegal_a", 64'(illegal_a), 64'(el));
      ref_dec(q[0], 64, 1'b0, ei, ef, el);
      chk("imm_b", imm_b, ei);
      chk("fmt_b", 64'(fmt_b), 64'(ef));
      chk("illegal_b", 64'(illegal_b), 64'(el));
      chk("rd", 64'({rd_a, rd_b}), 64'({q[0][11:7], q[0][11:7]}));
      chk("rs1", 64'({rs1_a, rs1_b}), 64'({q[0][19:15], q[0][19:15]}));
      chk("rs2", 64'({rs2_a, rs2_b}), 64'({q[0][24:20], q[0][24:20]}));
    end
  endtask

  // One clock: update the queue model from the pre-edge handshake, then compare after the edge.
  task automatic cycle();
    bit push, pop;
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() > 0);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(instr_word);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  vec_t tbl[$];
  logic [6:0] ops[10];

  initial begin
    tbl.push_back('{32'h123452B7, 64'h12345000,          64'h0000_0000_1234_5000, 3'd4, 1'b0, 5'd5});
    tbl.push_back('{32'hFFFFF517, 64'hFFFF_F000,         64'hFFFF_FFFF_FFFF_F000, 3'd4, 1'b0, 5'd10});
    tbl.push_back('{32'hFFF00093, 64'hFFFF_FFFF,         64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 5'd1});
    tbl.push_back('{32'hFFDFF0EF, 64'hFFFF_FFFC,         64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0, 5'd1});
    tbl.push_back('{32'h00000463, 64'd8,                 64'd8,                   3'd3, 1'b0, 5'd8});
    tbl.push_back('{32'h0021A623, 64'd12,                64'd12,                  3'd2, 1'b0, 5'd12});
    tbl.push_back('{32'h0000007F, 64'd0,                 64'd0,                   3'd7, 1'b1, 5'd0});
    tbl.push_back('{32'h4030D093, 64'd3,                 64'h403,                 3'd1, 1'b0, 5'd1});
    tbl.push_back('{32'h002081B3, 64'd0,                 64'd0,                   3'd0, 1'b0, 5'd3});
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33};

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'({in_ready_a, in_ready_b}), 64'd0);
    chk("rst_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    chk("rst_imm", imm_b | 64'(imm_a), 64'd0);
    chk("rst_fields", 64'({rd_a, rs1_a, rs2_a, fmt_a, illegal_a, rd_b, rs1_b, rs2_b, fmt_b, illegal_b}), 64'd0);
    rst = 1'b0;
    #1;
    check_state();

    // Table vectors, one at a time
    foreach (tbl[i]) begin
      in_valid = 1'b1; instr_word = tbl[i].instr; out_ready = 1'b1;
      cycle();
      chk("tbl_valid", 64'({out_valid_a, out_valid_b}), 64'd3);
      chk("tbl_imm32", 64'(imm_a), tbl[i].imm32);
      chk("tbl_imm64", imm_b, tbl[i].imm64);
      chk("tbl_fmt", 64'({fmt_a, fmt_b}), 64'({tbl[i].fmt, tbl[i].fmt}));
      chk("tbl_illegal", 64'({illegal_a, illegal_b}), 64'({tbl[i].ill, tbl[i].ill}));
      chk("tbl_rd", 64'(rd_a), 64'(tbl[i].rd));
      in_valid = 1'b0;
      cycle();
    end

    // Back-to-back JAL, BEQ, SW with no bubbles
    out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      in_valid = 1'b1; instr_word = tbl[i].instr;
      cycle();
      chk("b2b_valid", 64'(out_valid_a), 64'd1);
      chk("b2b_imm", 64'(imm_a), tbl[i].imm32);
    end
    in_valid = 1'b0;
    cycle();

    // Backpressure: third word held off until a slot frees
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; instr_word = tbl[i].instr;
      cycle();
    end
    chk("bp_full", 64'(in_ready_a), 64'd0);
    out_ready = 1'b1;
    cycle();
    chk("bp_head1", 64'(imm_a), tbl[1].imm32);
    cycle();
    chk("bp_head2", 64'(imm_a), tbl[2].imm32);
    in_valid = 1'b0;
    cycle();
    chk("bp_drain", 64'(out_valid_a), 64'd0);

    // Flush at count=2 with a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr_word = tbl[i].instr;
      cycle();
    end
    flush = 1'b1; instr_word = tbl[6].instr;
    cycle();
    chk("flush_empty", 64'({out_valid_a, out_valid_b}), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    cycle();

    // Asynchronous reset pulse between edges
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr_word = tbl[i].instr;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'({out_valid_a, out_valid_b}), 64'd0);
    chk("arst_in_ready", 64'({in_ready_a, in_ready_b}), 64'd0);
    chk("arst_imm", imm_b | 64'(imm_a), 64'd0);
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_state();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      instr_word = $urandom();
      if ($urandom_range(0, 7) != 0)
        instr_word[6:0] = ops[$urandom_range(0, 9)];
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
